// File: rtl/das_pkg.sv
// das_pkg: shared definitions for the four-channel delay-and-sum stage.
//   - default widths and depths used by das_sum4 and das_delay_line
//   - FSM state enumeration (IDLE / RUN)
//   - packed four-channel sample type and a full-precision adder helper
package das_pkg;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 16;
  localparam int DLY_W    = 4;
  localparam int LINE_LEN = 16;
  localparam int IDX_W    = 4;
  localparam int SUM_W    = DATA_W + 2;
  localparam int NUM_CH   = 4;

  // Index of the final accepted beat of a line
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Element [0] is channel 0
  typedef logic [NUM_CH-1:0][DATA_W-1:0] chan_samples_t;

  // Zero-extends every channel before adding, so four full-scale
  // samples (0x3FFFC) still fit without wrapping
  function automatic logic [SUM_W-1:0] sum4(input chan_samples_t s);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc = acc + SUM_W'(s[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/das_delay_line.sv
// das_delay_line: one channel's programmable sample delay.
//   A DEPTH-entry circular buffer written at the shared write pointer.
//   Ports:
//     clk         in   clock
//     we          in   write din at buf[wptr] (an accepted beat)
//     wptr        in   shared write pointer
//     din         in   current channel sample
//     delay       in   delay in samples for this channel
//     sample_idx  in   index of the current beat within the line
//     dout        out  selected sample (combinational)
module das_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int DLY_W  = 4,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DLY_W-1:0]  wptr,
  input  logic [DATA_W-1:0] din,
  input  logic [DLY_W-1:0]  delay,
  input  logic [IDX_W-1:0]  sample_idx,
  output logic [DATA_W-1:0] dout
);

  localparam int CMP_W = (DLY_W > IDX_W) ? DLY_W : IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DLY_W-1:0]  rd_addr;
  logic              too_early;

  // Buffer write: the current beat lands at the write pointer. Contents are
  // deliberately never cleared; stale entries are masked by the read rule.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wptr] = din;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read selection: delay 0 bypasses the buffer because buf[wptr] has not
  // been written yet this beat. A delay reaching back past the start of
  // the line contributes zero. The DLY_W-bit subtraction wraps mod DEPTH.
  always_comb begin
    rd_addr   = wptr - delay;
    too_early = CMP_W'(delay) > CMP_W'(sample_idx);
    if (delay == '0) begin
      dout = din;
    end else if (too_early) begin
      dout = '0;
    end else begin
      dout = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/das_sum4.sv
// das_sum4: four-channel delay-and-sum with per-line peak detection.
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     start                   pulse in IDLE begins a line
//     in_valid, ch0..ch3      one sample per channel per accepted beat
//     cfg_we/cfg_ch/cfg_delay per-channel delay register write
//     sample_req, busy        high while a line is running
//     out_valid/out_sum       delayed sum, two cycles after the beat
//     out_last                marks the final sum of the line
//     peak_valid              pulses with out_last
//     peak_val/peak_idx       line maximum and its first index, held
module das_sum4
  import das_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ch0,
  input  logic [DATA_W-1:0] ch1,
  input  logic [DATA_W-1:0] ch2,
  input  logic [DATA_W-1:0] ch3,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic [DLY_W-1:0]  cfg_delay,
  output logic              sample_req,
  output logic              busy,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_last,
  output logic              peak_valid,
  output logic [SUM_W-1:0]  peak_val,
  output logic [IDX_W-1:0]  peak_idx
);

  state_t state_q, state_d;
  logic   accept;

  logic [DLY_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
  logic [DLY_W-1:0] delay_q [NUM_CH];
  logic [DLY_W-1:0] delay_d [NUM_CH];

  chan_samples_t ch_in;
  chan_samples_t dly_samp;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  chan_samples_t    s1_samp_q, s1_samp_d;

  logic [SUM_W-1:0] s2_sum;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_last_q, out_last_d;
  logic             peak_valid_q, peak_valid_d;
  logic [SUM_W-1:0] peak_val_q, peak_val_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic [SUM_W-1:0] run_peak_q, run_peak_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;

  assign ch_in = {ch3, ch2, ch1, ch0};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start opens a line only from IDLE; the line closes on
  // the LINE_LEN-th accepted beat regardless of gaps in in_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (accept && (sample_idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a beat is only taken while running
  always_comb begin
    busy       = (state_q == RUN);
    sample_req = busy;
    accept     = busy && in_valid;
  end

  // Write pointer runs continuously across lines; the sample index restarts
  // at every start. Delay writes land next cycle so a write coinciding with
  // an accepted beat cannot affect that beat.
  always_comb begin
    wptr_d       = wptr_q;
    sample_idx_d = sample_idx_q;
    delay_d      = delay_q;
    if (accept) begin
      wptr_d       = wptr_q + 1'b1;
      sample_idx_d = sample_idx_q + 1'b1;
    end else if ((state_q == IDLE) && start) begin
      sample_idx_d = '0;
    end
    if (cfg_we) begin
      delay_d[cfg_ch] = cfg_delay;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      sample_idx_q <= '0;
      delay_q      <= '{default: '0};
    end else begin
      wptr_q       <= wptr_d;
      sample_idx_q <= sample_idx_d;
      delay_q      <= delay_d;
    end
  end

  // One delay line per channel, all sharing the write pointer and index
  for (genvar g = 0; g < NUM_CH; g++) begin : g_dly
    das_delay_line #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .DLY_W (DLY_W),
      .IDX_W (IDX_W)
    ) u_dly (
      .clk       (clk),
      .we        (accept),
      .wptr      (wptr_q),
      .din       (ch_in[g]),
      .delay     (delay_q[g]),
      .sample_idx(sample_idx_q),
      .dout      (dly_samp[g])
    );
  end

  assign s2_sum = sum4(s1_samp_q);

  // Two-stage pipeline. Stage 1 captures the selected samples with their
  // line index; stage 2 sums them and tracks the peak. The running peak is
  // seeded by index 0 rather than cleared on start, so the final sums of a
  // draining line never collide with the seeding of the next line.
  always_comb begin
    s1_valid_d   = accept;
    s1_last_d    = accept && (sample_idx_q == LAST_IDX);
    s1_idx_d     = s1_idx_q;
    s1_samp_d    = s1_samp_q;
    out_valid_d  = s1_valid_q;
    out_last_d   = s1_valid_q && s1_last_q;
    peak_valid_d = s1_valid_q && s1_last_q;
    out_sum_d    = out_sum_q;
    run_peak_d   = run_peak_q;
    run_idx_d    = run_idx_q;
    peak_val_d   = peak_val_q;
    peak_idx_d   = peak_idx_q;
    if (accept) begin
      s1_idx_d  = sample_idx_q;
      s1_samp_d = dly_samp;
    end
    if (s1_valid_q) begin
      out_sum_d = s2_sum;
      // Strict compare: ties keep the earlier index
      if ((s1_idx_q == '0) || (s2_sum > run_peak_q)) begin
        run_peak_d = s2_sum;
        run_idx_d  = s1_idx_q;
      end
      if (s1_last_q) begin
        peak_val_d = run_peak_d;
        peak_idx_d = run_idx_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_idx_q     <= '0;
      s1_samp_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_last_q   <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_val_q   <= '0;
      peak_idx_q   <= '0;
      run_peak_q   <= '0;
      run_idx_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_idx_q     <= s1_idx_d;
      s1_samp_q    <= s1_samp_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_last_q   <= out_last_d;
      peak_valid_q <= peak_valid_d;
      peak_val_q   <= peak_val_d;
      peak_idx_q   <= peak_idx_d;
      run_peak_q   <= run_peak_d;
      run_idx_q    <= run_idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_last   = out_last_q;
  assign peak_valid = peak_valid_q;
  assign peak_val   = peak_val_q;
  assign peak_idx   = peak_idx_q;

endmodule

// File: tb/tb_das_sum4.sv
// tb_das_sum4: directed and randomized stimulus for das_sum4, checked each
// cycle against a line-history reference model of the delay-and-sum rules.
module tb_das_sum4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] ch0, ch1, ch2, ch3;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_delay;
  logic        sample_req, busy, out_valid, out_last, peak_valid;
  logic [17:0] out_sum, peak_val;
  logic [3:0]  peak_idx;

  das_sum4 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .ch0       (ch0),
    .ch1       (ch1),
    .ch2       (ch2),
    .ch3       (ch3),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .sample_req(sample_req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .peak_valid(peak_valid),
    .peak_val  (peak_val),
    .peak_idx  (peak_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit last;
    int pv;
    int pi;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_delay [4];
  bit   mdl_run;
  int   mdl_idx;
  int   hist [4][16];
  int   lsum [16];
  int   mdl_pv, mdl_pi;
  int   cycle;
  int   pass_cnt, total_cnt, fail_cnt;

  // Single comparison point
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Compare all outputs against the model state after a clock edge
  task automatic checkOutput();
    exp_t e;
    checkVal("busy", {31'd0, busy}, {31'd0, mdl_run});
    checkVal("sample_req", {31'd0, sample_req}, {31'd0, mdl_run});
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      e = exp_q.pop_front();
      checkVal("out_valid", {31'd0, out_valid}, 32'd1);
      checkVal("out_sum", {14'd0, out_sum}, e.sum);
      checkVal("out_last", {31'd0, out_last}, {31'd0, e.last});
      checkVal("peak_valid", {31'd0, peak_valid}, {31'd0, e.last});
      if (e.last) begin
        mdl_pv = e.pv;
        mdl_pi = e.pi;
      end
    end else begin
      checkVal("out_valid_idle", {31'd0, out_valid}, 32'd0);
      checkVal("out_last_idle", {31'd0, out_last}, 32'd0);
      checkVal("peak_valid_idle", {31'd0, peak_valid}, 32'd0);
    end
    checkVal("peak_val", {14'd0, peak_val}, mdl_pv);
    checkVal("peak_idx", {28'd0, peak_idx}, mdl_pi);
  endtask

  // Advance the reference model by one cycle using the driven inputs, then
  // clock the DUT and compare
  task automatic clockCycle();
    bit   was_run;
    int   s;
    int   vals [4];
    exp_t e;
    if (reset) begin
      mdl_run = 0;
      mdl_idx = 0;
      for (int c = 0; c < 4; c++) mdl_delay[c] = 0;
      exp_q.delete();
      mdl_pv = 0;
      mdl_pi = 0;
    end else begin
      was_run = mdl_run;
      if (was_run && in_valid) begin
        vals[0] = int'(ch0); vals[1] = int'(ch1);
        vals[2] = int'(ch2); vals[3] = int'(ch3);
        s = 0;
        for (int c = 0; c < 4; c++) begin
          hist[c][mdl_idx] = vals[c];
          if (mdl_delay[c] <= mdl_idx) s += hist[c][mdl_idx - mdl_delay[c]];
        end
        lsum[mdl_idx] = s;
        e.sum  = s;
        e.last = (mdl_idx == 15);
        e.pv   = 0;
        e.pi   = 0;
        if (e.last) begin
          e.pv = lsum[0];
          for (int k = 1; k < 16; k++) begin
            if (lsum[k] > e.pv) begin
              e.pv = lsum[k];
              e.pi = k;
            end
          end
        end
        e.due = cycle + 2;
        exp_q.push_back(e);
        mdl_idx++;
        if (mdl_idx == 16) mdl_run = 0;
      end
      if (!was_run && start) begin
        mdl_run = 1;
        mdl_idx = 0;
      end
      if (cfg_we) mdl_delay[cfg_ch] = int'(cfg_delay);
    end
    @(posedge clk);
    #1;
    cycle++;
    checkOutput();
  endtask

  // Drive one cycle of inputs; pulses return low afterwards
  task automatic applyStimulus(input bit st, input bit iv,
                               input logic [15:0] c0, input logic [15:0] c1,
                               input logic [15:0] c2, input logic [15:0] c3,
                               input bit we, input logic [1:0] cch, input logic [3:0] cd);
    start = st; in_valid = iv;
    ch0 = c0; ch1 = c1; ch2 = c2; ch3 = c3;
    cfg_we = we; cfg_ch = cch; cfg_delay = cd;
    clockCycle();
    start = 0; in_valid = 0; cfg_we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic randomBeat(input bit st);
    applyStimulus(st, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);
  endtask

  initial begin
    int guard;
    int acc;
    logic [15:0] v;
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0; cycle = 0;
    mdl_run = 0; mdl_idx = 0; mdl_pv = 0; mdl_pi = 0;
    for (int c = 0; c < 4; c++) mdl_delay[c] = 0;
    reset = 1; start = 0; in_valid = 0;
    ch0 = 0; ch1 = 0; ch2 = 0; ch3 = 0;
    cfg_we = 0; cfg_ch = 0; cfg_delay = 0;

    $display("[TB] reset");
    clockCycle();
    clockCycle();
    checkVal("reset_out_sum", {14'd0, out_sum}, 32'd0);
    reset = 0;

    $display("[TB] basic sum");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'h0050, 16'h00FF, 16'h00FF, 16'h0010, 0, 0, 0);
    idle(1);
    checkVal("basic_valid", {31'd0, out_valid}, 32'd1);
    checkVal("basic_sum", {14'd0, out_sum}, 32'h25E);
    for (int i = 0; i < 15; i++) randomBeat(0);
    idle(3);

    $display("[TB] delay on channel 0");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'd0, 4'd2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 16'(i + 1), 0, 0, 0, 0, 0, 0);
    idle(1);
    checkVal("delay_last_sum", {14'd0, out_sum}, 32'd14);
    checkVal("delay_last_flag", {31'd0, out_last}, 32'd1);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'd0, 4'd0);

    $display("[TB] full scale");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    idle(1);
    checkVal("full_scale_sum", {14'd0, out_sum}, 32'h3FFFC);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    idle(3);

    $display("[TB] peak tie-break");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      v = (i == 5 || i == 9) ? 16'h0100 : 16'($urandom_range(0, 255));
      applyStimulus(0, 1, v, 0, 0, 0, 0, 0, 0);
    end
    idle(1);
    checkVal("tie_peak_valid", {31'd0, peak_valid}, 32'd1);
    checkVal("tie_peak_val", {14'd0, peak_val}, 32'h100);
    checkVal("tie_peak_idx", {28'd0, peak_idx}, 32'd5);
    idle(2);

    $display("[TB] handshake gaps and mid-line start");
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'(c), 4'($urandom_range(0, 5)));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 16; b++) begin
      applyStimulus(b == 8, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);
      if (b < 15) begin
        applyStimulus(b == 3, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
      end
    end
    checkVal("hs_busy_drop", {31'd0, busy}, 32'd0);
    idle(3);

    $display("[TB] random lines with back-to-back starts");
    for (int l = 0; l < 6; l++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 2'($urandom_range(0, 3)), 4'($urandom));
      guard = 0;
      while (mdl_run && guard < 400) begin
        applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), 4'($urandom));
        guard++;
      end
      checkVal("line_terminated", {31'd0, mdl_run}, 32'd0);
    end
    idle(3);

    $display("[TB] reset mid-line");
    for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'(c), 4'($urandom_range(1, 4)));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) randomBeat(0);
    reset = 1;
    randomBeat(0);
    reset = 0;
    checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_out_sum", {14'd0, out_sum}, 32'd0);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 16; i++) randomBeat(0);
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
